// File: rtl/axi_b_resp_tracker_if.sv
// ---------------------------------------------------------------------------
// axi_b_resp_tracker_if
//  Bundles the signals between the write-response tracker and the rest of the
//  system: the AW issue notification, the AXI B channel, the client
//  completion stage, the outstanding count and the sticky error flags.
//
//  Modports
//   slave  : the tracker itself. It receives aw_issue/aw_id, the B beat,
//            done_ready and err_clear. It drives aw_full, bready, the
//            completion stage, the outstanding count and the error flags.
//   master : the surrounding system (bridge, memory slave, client), which sees
//            the same signals with the opposite directions.
// ---------------------------------------------------------------------------
interface axi_b_resp_tracker_if #(
    parameter int C_ID_WIDTH = 4,
    parameter int C_AWIDTH   = 3
);
    // AW issue side
    logic                  aw_issue;
    logic [C_ID_WIDTH-1:0] aw_id;
    logic                  aw_full;
    // AXI B channel
    logic [C_ID_WIDTH-1:0] bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Client completion stage
    logic                  done_valid;
    logic [C_ID_WIDTH-1:0] done_id;
    logic [1:0]            done_resp;
    logic                  done_ready;
    // Status and sticky errors
    logic [C_AWIDTH:0]     outstanding;
    logic                  err_id;
    logic                  err_resp;
    logic                  err_orphan;
    logic                  err_overflow;
    logic                  err_timeout;
    logic                  err_clear;

    modport slave (
        input  aw_issue, aw_id, bid, bresp, bvalid, done_ready, err_clear,
        output aw_full, bready, done_valid, done_id, done_resp, outstanding,
               err_id, err_resp, err_orphan, err_overflow, err_timeout
    );

    modport master (
        output aw_issue, aw_id, bid, bresp, bvalid, done_ready, err_clear,
        input  aw_full, bready, done_valid, done_id, done_resp, outstanding,
               err_id, err_resp, err_orphan, err_overflow, err_timeout
    );
endinterface

// File: rtl/axi_b_resp_tracker.sv
// ---------------------------------------------------------------------------
// axi_b_resp_tracker
//  Initiator-side AXI write-response collector. Every issued AWID goes into an
//  in-order expected-ID FIFO. Each accepted B beat pops the FIFO head, and
//  the beat is checked against that head and against an OKAY response. The
//  beat then goes to the client through a registered valid/ready stage.
//  Errors are flagged by sticky bits that only err_clear removes.
//
//  Parameters
//   C_ID_WIDTH : width of AWID/BID
//   C_AWIDTH   : expected-ID FIFO address width
//   C_DEPTH    : expected-ID FIFO depth, must equal 2**C_AWIDTH
//   C_TIMEOUT  : cycles with writes outstanding and no response before
//                err_timeout is set; 0 disables the timeout
//
//  Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : axi_b_resp_tracker_if.slave carrying
//           aw_issue/aw_id/aw_full, bid/bresp/bvalid/bready,
//           done_valid/done_id/done_resp/done_ready, outstanding,
//           err_id/err_resp/err_orphan/err_overflow/err_timeout, err_clear
// ---------------------------------------------------------------------------
module axi_b_resp_tracker #(
    parameter int C_ID_WIDTH = 4,
    parameter int C_AWIDTH   = 3,
    parameter int C_DEPTH    = 8,
    parameter int C_TIMEOUT  = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_b_resp_tracker_if.slave    bus
);

    localparam int              CW      = C_AWIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(C_DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    // Expected-ID FIFO storage and bookkeeping
    logic [C_ID_WIDTH-1:0] fifo_mem_r [C_DEPTH];
    logic [C_AWIDTH-1:0]   wr_ptr_r;
    logic [C_AWIDTH-1:0]   rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  full_r;

    // Handshake decode
    logic                  bready_s;
    logic                  b_hs_s;
    logic                  push_s;
    logic                  overflow_s;
    logic                  empty_s;
    logic [C_ID_WIDTH-1:0] head_id_s;

    // Completion stage
    logic                  done_valid_r;
    logic [C_ID_WIDTH-1:0] done_id_r;
    logic [1:0]            done_resp_r;

    // Error set events and sticky flags
    logic                  err_id_set_s;
    logic                  err_resp_set_s;
    logic                  err_orphan_set_s;
    logic                  timeout_set_s;
    logic                  err_id_r;
    logic                  err_resp_r;
    logic                  err_orphan_r;
    logic                  err_overflow_r;
    logic                  err_timeout_r;

    // Handshake, push/pop and error-event decode
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        head_id_s = fifo_mem_r[rd_ptr_r];
        // A B beat is only taken while a write is outstanding and the
        // completion register is free or being drained this very cycle.
        bready_s  = ~empty_s & (~done_valid_r | bus.done_ready);
        b_hs_s    = bus.bvalid & bready_s;
        // A pop in the same cycle frees a slot, so a push into a full FIFO
        // is still legal then.
        push_s     = bus.aw_issue & (~full_r | b_hs_s);
        overflow_s = bus.aw_issue & full_r & ~b_hs_s;

        case ({push_s, b_hs_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase

        err_id_set_s     = b_hs_s & (bus.bid != head_id_s);
        err_resp_set_s   = b_hs_s & (bus.bresp != 2'b00);
        err_orphan_set_s = bus.bvalid & empty_s;
    end

    // Expected-ID FIFO: pointers wrap naturally at C_DEPTH = 2**C_AWIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {C_AWIDTH{1'b0}};
            rd_ptr_r <= {C_AWIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            for (int i = 0; i < C_DEPTH; i++) begin
                fifo_mem_r[i] <= {C_ID_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.aw_id;
                wr_ptr_r             <= wr_ptr_r + {{(C_AWIDTH-1){1'b0}}, 1'b1};
            end
            if (b_hs_s) begin
                rd_ptr_r <= rd_ptr_r + {{(C_AWIDTH-1){1'b0}}, 1'b1};
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Registered completion stage: loads on a B handshake, holds until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_valid_r <= 1'b0;
            done_id_r    <= {C_ID_WIDTH{1'b0}};
            done_resp_r  <= 2'b00;
        end else if (b_hs_s) begin
            done_valid_r <= 1'b1;
            done_id_r    <= bus.bid;
            done_resp_r  <= bus.bresp;
        end else if (bus.done_ready) begin
            done_valid_r <= 1'b0;
        end
    end

    // Response timeout watchdog
    generate
        if (C_TIMEOUT != 0) begin : g_timeout
            localparam int             TW     = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
            localparam logic [TW-1:0]  TO_MAX = TW'(C_TIMEOUT - 1);
            logic [TW-1:0]             to_cnt_r;

            // Idle-cycle counter; restarts on progress, saturates at the limit
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    to_cnt_r <= {TW{1'b0}};
                end else if (b_hs_s | empty_s) begin
                    to_cnt_r <= {TW{1'b0}};
                end else if (to_cnt_r != TO_MAX) begin
                    to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end

            assign timeout_set_s = ~empty_s & ~b_hs_s & (to_cnt_r == TO_MAX);
        end else begin : g_no_timeout
            assign timeout_set_s = 1'b0;
        end
    endgenerate

    // Sticky error flags; a set event in the clear cycle wins over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_id_r       <= 1'b0;
            err_resp_r     <= 1'b0;
            err_orphan_r   <= 1'b0;
            err_overflow_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            err_id_r       <= err_id_set_s     | (err_id_r       & ~bus.err_clear);
            err_resp_r     <= err_resp_set_s   | (err_resp_r     & ~bus.err_clear);
            err_orphan_r   <= err_orphan_set_s | (err_orphan_r   & ~bus.err_clear);
            err_overflow_r <= overflow_s       | (err_overflow_r & ~bus.err_clear);
            err_timeout_r  <= timeout_set_s    | (err_timeout_r  & ~bus.err_clear);
        end
    end

    assign bus.aw_full      = full_r;
    assign bus.bready       = bready_s;
    assign bus.done_valid   = done_valid_r;
    assign bus.done_id      = done_id_r;
    assign bus.done_resp    = done_resp_r;
    assign bus.outstanding  = count_r;
    assign bus.err_id       = err_id_r;
    assign bus.err_resp     = err_resp_r;
    assign bus.err_orphan   = err_orphan_r;
    assign bus.err_overflow = err_overflow_r;
    assign bus.err_timeout  = err_timeout_r;

endmodule
